twi_frame_sequencer: RTL and testbench

TWI_FRAME_SEQUENCER -- requirements
Module: twi_frame_sequencer

---
 rtl/twi_frame_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_twi_frame_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/twi_frame_sequencer.sv
`default_nettype none
//============================================================================
// Module   : twi_frame_sequencer
// Purpose  : Passive TWI (I2C-style) bus observer. It synchronizes the raw
//            scl/sda lines, detects START / repeated START / STOP, assembles
//            8 data bits plus the 9th (ACK) bit, and presents each completed
//            byte as a valid/ready record.
// Ports    : clk        - system clock
//            reset      - synchronous, active-high reset
//            scl, sda   - raw bus lines, asynchronous to clk
//            out_ready  - consumer accepts the record when high with out_valid
//            out_valid  - byte record available
//            out_data   - received byte (MSB first on the bus)
//            out_ack    - sampled 9th bit (0 = ACK, 1 = NACK)
//            out_first  - byte is the first after START / repeated START
//            start_det  - one-cycle pulse on START / repeated START
//            stop_det   - one-cycle pulse on STOP
//            bus_busy   - high between START and STOP
//            overrun    - sticky; a completed byte was dropped
// Options  : TWI_GLITCH_FILTER_EN - when defined, each synchronized line
//            changes its filtered value only after 3 consecutive equal
//            samples, so pulses shorter than 3 clk are rejected.
// Revision : 1.0 - initial release
//============================================================================
module twi_frame_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_ack,
  output logic       out_first,
  output logic       start_det,
  output logic       stop_det,
  output logic       bus_busy,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BITS = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Two-flop synchronizers; reset to 1 so an idle bus produces no edge.
  logic scl_m, scl_s, sda_m, sda_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
    end else begin
      scl_m <= scl;
      scl_s <= scl_m;
      sda_m <= sda;
      sda_s <= sda_m;
    end
  end

  // Previous-cycle copies of the (possibly filtered) line values. They also
  // act as the held filtered value when the filter is enabled.
  logic scl_p, sda_p;
  logic scl_f, sda_f;

`ifdef TWI_GLITCH_FILTER_EN
  // Two older samples of each synchronized line; the filtered value only
  // follows the line once three consecutive samples agree.
  logic [1:0] scl_h, sda_h;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_h <= 2'b11;
      sda_h <= 2'b11;
    end else begin
      scl_h <= {scl_h[0], scl_s};
      sda_h <= {sda_h[0], sda_s};
    end
  end

  assign scl_f = ((scl_s == scl_h[0]) && (scl_s == scl_h[1])) ? scl_s : scl_p;
  assign sda_f = ((sda_s == sda_h[0]) && (sda_s == sda_h[1])) ? sda_s : sda_p;
`else
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  end

  // Requiring scl high in both cycles excludes sda edges that coincide
  // with an scl edge.
  logic start_ev, stop_ev, scl_rise;
  assign start_ev = scl_f & scl_p &  sda_p & ~sda_f;
  assign stop_ev  = scl_f & scl_p & ~sda_p &  sda_f;
  assign scl_rise = scl_f & ~scl_p;

  // Sequencer state and next-state values
  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic       first, first_n;
  logic       busy_n;
  logic       valid_n, ack_n, ofirst_n, overrun_n;
  logic [7:0] data_n;
  logic       start_n, stop_n;
  logic       byte_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'd0;
      first     <= 1'b0;
      bus_busy  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_ack   <= 1'b0;
      out_first <= 1'b0;
      overrun   <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      first     <= first_n;
      bus_busy  <= busy_n;
      out_valid <= valid_n;
      out_data  <= data_n;
      out_ack   <= ack_n;
      out_first <= ofirst_n;
      overrun   <= overrun_n;
      start_det <= start_n;
      stop_det  <= stop_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    first_n   = first;
    busy_n    = bus_busy;
    valid_n   = out_valid;
    data_n    = out_data;
    ack_n     = out_ack;
    ofirst_n  = out_first;
    overrun_n = overrun;
    start_n   = 1'b0;
    stop_n    = 1'b0;
    byte_done = 1'b0;

    if (out_valid && out_ready) begin
      valid_n = 1'b0;
    end

    if (stop_ev) begin
      state_n   = IDLE;
      bit_cnt_n = 3'd0;
      shreg_n   = 8'd0;
      first_n   = 1'b0;
      busy_n    = 1'b0;
      stop_n    = 1'b1;
    end else if (start_ev) begin
      // START and repeated START both restart the byte from scratch.
      state_n   = BITS;
      bit_cnt_n = 3'd0;
      shreg_n   = 8'd0;
      first_n   = 1'b1;
      busy_n    = 1'b1;
      start_n   = 1'b1;
    end else if (scl_rise) begin
      case (state)
        BITS: begin
          shreg_n = {shreg[6:0], sda_f};
          if (bit_cnt == 3'd7) begin
            state_n   = ACK;
            bit_cnt_n = 3'd0;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
        ACK: begin
          byte_done = 1'b1;
          first_n   = 1'b0;
          state_n   = BITS;
          bit_cnt_n = 3'd0;
        end
        default: begin
          // scl activity while idle is ignored
        end
      endcase
    end

    // A consumer accepting in the same cycle frees the slot for the new byte.
    if (byte_done) begin
      if (!out_valid || out_ready) begin
        valid_n  = 1'b1;
        data_n   = shreg;
        ack_n    = sda_f;
        ofirst_n = first;
      end else begin
        overrun_n = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_twi_frame_sequencer.sv
`default_nettype none
//============================================================================
// Module   : tb_twi_frame_sequencer
// Purpose  : Self-checking bench for twi_frame_sequencer. Bit-bangs TWI
//            frames, predicts the emitted records from the bytes sent and
//            compares them with what the consumer side accepts.
// Revision : 1.0 - initial release
//============================================================================
module tb_twi_frame_sequencer;

  localparam int H = 6;  // clk cycles per bus phase
`ifdef TWI_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ack;
  logic       out_first;
  logic       start_det;
  logic       stop_det;
  logic       bus_busy;
  logic       overrun;

  twi_frame_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ack   (out_ack),
    .out_first (out_first),
    .start_det (start_det),
    .stop_det  (stop_det),
    .bus_busy  (bus_busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  logic [9:0] obs_q[$];  // {data, ack, first} accepted by the consumer
  logic [9:0] exp_q[$];  // {data, ack, first} predicted from the bus traffic

  always @(negedge clk) begin
    if (!reset) begin
      if (start_det) start_cnt++;
      if (stop_det) stop_cnt++;
      if (out_valid && out_ready) obs_q.push_back({out_data, out_ack, out_first});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_c;
    sda = 1'b1; hold(H);
    scl = 1'b1; hold(H);
    sda = 1'b0; hold(H);
    scl = 1'b0; hold(H);
  endtask

  task automatic bit_c(input logic b);
    sda = b;    hold(H);
    scl = 1'b1; hold(H);
    scl = 1'b0; hold(H);
  endtask

  task automatic stop_c;
    sda = 1'b0; hold(H);
    scl = 1'b1; hold(H);
    sda = 1'b1; hold(H);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic a);
    for (int i = 7; i >= 0; i--) bit_c(d[i]);
    bit_c(a);
  endtask

  task automatic drain(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check(tag, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  // Changes sda with scl high and reports after how many clk edges the
  // matching detect pulse appears and how many cycles it lasts.
  task automatic measure(input logic v, output int lat, output int width);
    lat = -1;
    width = 0;
    @(posedge clk);
    #1 sda = v;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (v ? stop_det : start_det) begin
        if (lat < 0) lat = k;
        width++;
      end
    end
  endtask

  initial begin
    int s0, p0, lat, width, n;
    logic [7:0] d;
    logic a;

    hold(5);
    check("reset_outs", {out_valid, out_ack, out_first, start_det, stop_det, bus_busy, overrun}, 0);
    check("reset_data", out_data, 8'h00);
    reset = 1'b0;
    hold(5);

    // Detect latency and pulse width on an idle bus
    measure(1'b0, lat, width);
    check("start_latency", lat, LAT);
    check("start_width", width, 1);
    check("busy_after_start", bus_busy, 1);
    measure(1'b1, lat, width);
    check("stop_latency", lat, LAT);
    check("stop_width", width, 1);
    check("busy_after_stop", bus_busy, 0);
    obs_q.delete();

    // Single byte 0xA5 with ACK
    s0 = start_cnt; p0 = stop_cnt;
    start_c;
    send_byte(8'hA5, 1'b0);
    stop_c;
    hold(12);
    exp_q.push_back({8'hA5, 1'b0, 1'b1});
    drain("single");
    check("single_starts", start_cnt - s0, 1);
    check("single_stops", stop_cnt - p0, 1);
    check("single_busy", bus_busy, 0);

    // Two bytes, second NACKed
    start_c;
    send_byte(8'h50, 1'b0);
    send_byte(8'h3C, 1'b1);
    stop_c;
    hold(12);
    exp_q.push_back({8'h50, 1'b0, 1'b1});
    exp_q.push_back({8'h3C, 1'b1, 1'b0});
    drain("two");

    // Random frames of 1..3 bytes
    for (int f = 0; f < 5; f++) begin
      s0 = start_cnt; p0 = stop_cnt;
      n = $urandom_range(1, 3);
      start_c;
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        a = 1'($urandom_range(0, 1));
        send_byte(d, a);
        exp_q.push_back({d, a, (i == 0)});
      end
      stop_c;
      hold(12);
      drain("rand");
      check("rand_starts", start_cnt - s0, 1);
      check("rand_stops", stop_cnt - p0, 1);
    end

    // Repeated START after 4 bits, then 0x7E
    s0 = start_cnt;
    start_c;
    for (int i = 0; i < 4; i++) bit_c(1'b1);
    start_c;
    send_byte(8'h7E, 1'b0);
    stop_c;
    hold(12);
    exp_q.push_back({8'h7E, 1'b0, 1'b1});
    drain("rstart");
    check("rstart_starts", start_cnt - s0, 2);

    // Overrun: consumer stalls across two bytes
    out_ready = 1'b0;
    start_c;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    stop_c;
    hold(12);
    check("ovr_valid", out_valid, 1);
    check("ovr_data", out_data, 8'h11);
    check("ovr_first", out_first, 1);
    check("ovr_flag", overrun, 1);
    out_ready = 1'b1;
    hold(4);
    check("ovr_valid_drop", out_valid, 0);
    check("ovr_sticky", overrun, 1);
    exp_q.push_back({8'h11, 1'b0, 1'b1});
    drain("ovr");

    // Reset in the middle of a byte
    start_c;
    for (int i = 0; i < 5; i++) bit_c(1'b1);
    reset = 1'b1;
    scl = 1'b1;
    sda = 1'b1;
    hold(5);
    reset = 1'b0;
    hold(12);
    check("midrst_outs", {out_valid, out_ack, out_first, start_det, stop_det, bus_busy, overrun}, 0);
    check("midrst_data", out_data, 8'h00);
    drain("midrst");

`ifdef TWI_GLITCH_FILTER_EN
    // Short low glitch on sda with scl high must not look like a START
    s0 = start_cnt; p0 = stop_cnt;
    sda = 1'b0; hold(2);
    sda = 1'b1; hold(12);
    check("glitch_starts", start_cnt - s0, 0);
    sda = 1'b0; hold(4);
    sda = 1'b1; hold(12);
    check("pulse_starts", start_cnt - s0, 1);
    check("pulse_stops", stop_cnt - p0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
